// File: rtl/ysyx_24100005_pkg.sv
// Shared constants for the ysyx_24100005 NPC core: datapath defaults and
// the RV32 major opcodes used by the decoder's key lookups.
package ysyx_24100005_pkg;

    localparam int          DEFAULT_DATA_WIDTH = 32;
    localparam int          DEFAULT_ADDR_WIDTH = 5;
    localparam logic [31:0] DEFAULT_PC_RESET   = 32'h8000_0000;

    localparam int OPCODE_LEN = 7;

    localparam logic [OPCODE_LEN-1:0] OP_IMM = 7'b0010011;
    localparam logic [OPCODE_LEN-1:0] AUIPC  = 7'b0010111;
    localparam logic [OPCODE_LEN-1:0] JAL    = 7'b1101111;
    localparam logic [OPCODE_LEN-1:0] JALR   = 7'b1100111;
    localparam logic [OPCODE_LEN-1:0] LOAD   = 7'b0000011;
    localparam logic [OPCODE_LEN-1:0] STORE  = 7'b0100011;
    localparam logic [OPCODE_LEN-1:0] SYSTEM = 7'b1110011;

endpackage

// File: rtl/ysyx_24100005_MuxKeyWithDefault.sv
// Priority key lookup: returns the data of the first {key,data} pair whose
// key equals the input key, or the default when nothing matches. The first
// listed pair sits in the MSBs of the packed table.
module ysyx_24100005_MuxKeyWithDefault #(
    parameter int NR_KEY   = 4,
    parameter int KEY_LEN  = 7,
    parameter int DATA_LEN = 32
) (
    input  logic [KEY_LEN-1:0]                  key,
    input  logic [DATA_LEN-1:0]                 default_out,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
    output logic [DATA_LEN-1:0]                 out
);

    localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

    // Scan from the last entry to the first so that the lowest-index match
    // is assigned last and therefore wins.
    // NOTE: out receives the default before the loop, so every path assigns
    // it and no latch is inferred.
    always_comb begin
        out = default_out;
        for (int i = NR_KEY - 1; i >= 0; i--) begin
            if (lut[(NR_KEY - i) * PAIR_LEN - 1 -: KEY_LEN] == key) begin
                out = lut[(NR_KEY - i) * PAIR_LEN - 1 - KEY_LEN -: DATA_LEN];
            end
        end
    end

endmodule

// File: rtl/ysyx_24100005_Reg.sv
// Generic load-enabled register with asynchronous active-high reset.
// Used for the program counter.
module ysyx_24100005_Reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic             wen
);

    // Hold RESET_VAL while rst is high; otherwise load din when enabled.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= RESET_VAL;
        end else if (wen) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/ysyx_24100005_RegisterFile.sv
// 2^ADDR_WIDTH-entry general-purpose register file: one synchronous write
// port, two combinational read ports, x0 hard-wired to zero, no bypass.
module ysyx_24100005_RegisterFile #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2
);

    localparam int NR_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [NR_REGS];

    // Clear every entry on reset; otherwise write any entry except x0.
    // NOTE: the whole array is reset here because the core relies on all
    // registers reading 0 after reset; this forces flops rather than a RAM
    // macro, which is acceptable for a 32-entry file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NR_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wen && (waddr != '0)) begin
            r_regs[waddr] <= wdata;
        end
    end

    // Combinational reads; index 0 is forced to zero so x0 never depends
    // on storage contents.
    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : r_regs[raddr1];
        rdata2 = (raddr2 == '0) ? '0 : r_regs[raddr2];
    end

endmodule

// File: rtl/ysyx_24100005_core_regs.sv
// State and selection block of the single-cycle NPC: PC register,
// general-purpose register file and the decoder's key mux.
module ysyx_24100005_core_regs
    import ysyx_24100005_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] PC_RESET   = DATA_WIDTH'(DEFAULT_PC_RESET),
    parameter int                    NR_KEY     = 4,
    parameter int                    KEY_LEN    = OPCODE_LEN,
    parameter int                    MUX_LEN    = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                pc_wen,
    input  logic [DATA_WIDTH-1:0]               pc_din,
    output logic [DATA_WIDTH-1:0]               pc,
    input  logic                                rf_wen,
    input  logic [ADDR_WIDTH-1:0]               rf_waddr,
    input  logic [DATA_WIDTH-1:0]               rf_wdata,
    input  logic [ADDR_WIDTH-1:0]               rs1addr,
    input  logic [ADDR_WIDTH-1:0]               rs2addr,
    output logic [DATA_WIDTH-1:0]               rs1data,
    output logic [DATA_WIDTH-1:0]               rs2data,
    input  logic [KEY_LEN-1:0]                  mux_key,
    input  logic [MUX_LEN-1:0]                  mux_default,
    input  logic [NR_KEY*(KEY_LEN+MUX_LEN)-1:0] mux_lut,
    output logic [MUX_LEN-1:0]                  mux_out
);

    ysyx_24100005_Reg #(
        .WIDTH     (DATA_WIDTH),
        .RESET_VAL (PC_RESET)
    ) u_pc (
        .clk  (clk),
        .rst  (rst),
        .din  (pc_din),
        .dout (pc),
        .wen  (pc_wen)
    );

    ysyx_24100005_RegisterFile #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rf (
        .clk    (clk),
        .rst    (rst),
        .wen    (rf_wen),
        .waddr  (rf_waddr),
        .wdata  (rf_wdata),
        .raddr1 (rs1addr),
        .raddr2 (rs2addr),
        .rdata1 (rs1data),
        .rdata2 (rs2data)
    );

    ysyx_24100005_MuxKeyWithDefault #(
        .NR_KEY   (NR_KEY),
        .KEY_LEN  (KEY_LEN),
        .DATA_LEN (MUX_LEN)
    ) u_mux (
        .key         (mux_key),
        .default_out (mux_default),
        .lut         (mux_lut),
        .out         (mux_out)
    );

endmodule

// File: tb/tb_ysyx_24100005_core_regs.sv
// Directed bench for ysyx_24100005_core_regs with an expected-value queue.
module tb_ysyx_24100005_core_regs;
    import ysyx_24100005_pkg::*;

    localparam logic [31:0] PC_RST = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         pc_wen = 1'b0;
    logic [31:0]  pc_din = '0;
    logic [31:0]  pc;
    logic         rf_wen = 1'b0;
    logic [4:0]   rf_waddr = '0;
    logic [31:0]  rf_wdata = '0;
    logic [4:0]   rs1addr = '0;
    logic [4:0]   rs2addr = '0;
    logic [31:0]  rs1data;
    logic [31:0]  rs2data;
    logic [6:0]   mux_key = '0;
    logic [31:0]  mux_default = '0;
    logic [155:0] mux_lut = '0;
    logic [31:0]  mux_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic [31:0] model [32];

    always #5 clk = ~clk;

    ysyx_24100005_core_regs dut (
        .clk         (clk),
        .rst         (rst),
        .pc_wen      (pc_wen),
        .pc_din      (pc_din),
        .pc          (pc),
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .rs1addr     (rs1addr),
        .rs2addr     (rs2addr),
        .rs1data     (rs1data),
        .rs2data     (rs2data),
        .mux_key     (mux_key),
        .mux_default (mux_default),
        .mux_lut     (mux_lut),
        .mux_out     (mux_out)
    );

    // Push an expected value when the stimulus that determines it is driven.
    task automatic expect_val(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    // Pop the oldest expectation and compare it with an observed DUT value.
    task automatic check(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: observed %h expected <none>", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                n_bad++;
                $error("FAIL %s: observed %h expected %h", t, obs, e);
            end
        end
    endtask

    task automatic to_negedge();
        @(negedge clk);
    endtask

    task automatic through_posedge();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [155:0] pack_lut(
        input logic [6:0] k0, input logic [31:0] d0,
        input logic [6:0] k1, input logic [31:0] d1,
        input logic [6:0] k2, input logic [31:0] d2,
        input logic [6:0] k3, input logic [31:0] d3);
        return {k0, d0, k1, d1, k2, d2, k3, d3};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset asserted between edges takes effect immediately.
        #2;
        rst = 1'b1;
        rs1addr = 5'd5;
        rs2addr = 5'd5;
        expect_val("reset_pc", PC_RST);
        expect_val("reset_rs1_x5", 32'h0);
        expect_val("reset_rs2_x5", 32'h0);
        #1;
        check(pc);
        check(rs1data);
        check(rs2data);

        // Edges while reset is high perform no update.
        to_negedge();
        pc_wen = 1'b1;
        pc_din = 32'h1111_2222;
        rf_wen = 1'b1;
        rf_waddr = 5'd5;
        rf_wdata = 32'h5555_5555;
        expect_val("reset_edge_pc", PC_RST);
        expect_val("reset_edge_x5", 32'h0);
        through_posedge();
        check(pc);
        check(rs1data);

        // Mux lookups are live during reset.
        mux_lut = pack_lut(OP_IMM, 32'd1, AUIPC, 32'd2, JAL, 32'd3, JALR, 32'd4);
        mux_default = 32'hFFFF_FFFF;
        mux_key = JAL;
        expect_val("mux_jal", 32'd3);
        #1 check(mux_out);
        mux_key = OP_IMM;
        expect_val("mux_first_entry", 32'd1);
        #1 check(mux_out);
        mux_key = JALR;
        expect_val("mux_last_entry", 32'd4);
        #1 check(mux_out);
        mux_key = LOAD;
        expect_val("mux_default", 32'hFFFF_FFFF);
        #1 check(mux_out);
        mux_lut = pack_lut(OP_IMM, 32'd1, STORE, 32'h0000_0022, JAL, 32'd3, STORE, 32'h0000_0044);
        mux_key = STORE;
        expect_val("mux_duplicate", 32'h0000_0022);
        #1 check(mux_out);
        mux_lut = pack_lut(SYSTEM, 32'hA0A0_A0A0, SYSTEM, 32'hB1, SYSTEM, 32'hC2, SYSTEM, 32'hD3);
        mux_key = SYSTEM;
        expect_val("mux_all_match", 32'hA0A0_A0A0);
        #1 check(mux_out);
        mux_key = 7'b1111111;
        mux_default = 32'h1357_9BDF;
        expect_val("mux_default2", 32'h1357_9BDF);
        #1 check(mux_out);

        // Release reset and load the PC.
        to_negedge();
        rst = 1'b0;
        rf_wen = 1'b0;
        pc_wen = 1'b1;
        pc_din = 32'h8000_0004;
        expect_val("pc_load", 32'h8000_0004);
        through_posedge();
        check(pc);

        // PC holds with pc_wen low.
        to_negedge();
        pc_wen = 1'b0;
        pc_din = 32'hDEAD_0000;
        for (int i = 0; i < 3; i++) begin
            expect_val("pc_hold", 32'h8000_0004);
            through_posedge();
            check(pc);
        end

        // Write x3 with both read ports on x3: old value until the edge.
        for (int i = 0; i < 32; i++) model[i] = '0;
        to_negedge();
        rf_wen = 1'b1;
        rf_waddr = 5'd3;
        rf_wdata = 32'hDEAD_BEEF;
        rs1addr = 5'd3;
        rs2addr = 5'd3;
        expect_val("rdw_x3_old", 32'h0);
        #1 check(rs1data);
        expect_val("x3_rs1_new", 32'hDEAD_BEEF);
        expect_val("x3_rs2_new", 32'hDEAD_BEEF);
        through_posedge();
        check(rs1data);
        check(rs2data);
        model[3] = 32'hDEAD_BEEF;

        // Overwrite x3: still no bypass with a non-zero old value.
        to_negedge();
        rf_wdata = 32'hCAFE_F00D;
        expect_val("rdw_x3_nonzero_old", 32'hDEAD_BEEF);
        #1 check(rs2data);
        expect_val("x3_overwrite", 32'hCAFE_F00D);
        through_posedge();
        check(rs1data);
        model[3] = 32'hCAFE_F00D;

        // Writes to x0 are discarded.
        to_negedge();
        rf_waddr = 5'd0;
        rf_wdata = 32'h0000_1234;
        rs1addr = 5'd0;
        through_posedge();
        expect_val("x0_zero", 32'h0);
        check(rs1data);

        // Fill x1..x31 with distinct values, then read back on both ports.
        for (int i = 1; i < 32; i++) begin
            to_negedge();
            rf_waddr = 5'(i);
            rf_wdata = 32'h0101_0101 * i ^ 32'hA5A5_0000;
            model[i] = rf_wdata;
        end
        to_negedge();
        rf_wen = 1'b0;
        rf_wdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 32; i++) begin
            rs1addr = 5'(i);
            rs2addr = 5'(31 - i);
            expect_val("rf_rs1_read", model[i]);
            expect_val("rf_rs2_read", model[31 - i]);
            #1;
            check(rs1data);
            check(rs2data);
        end

        // Reset asserted with a write pending overrides it and clears state.
        to_negedge();
        rf_wen = 1'b1;
        rf_waddr = 5'd7;
        rf_wdata = 32'h7777_7777;
        pc_wen = 1'b1;
        pc_din = 32'h9000_0000;
        rst = 1'b1;
        rs1addr = 5'd7;
        rs2addr = 5'd3;
        expect_val("mid_reset_x7", 32'h0);
        expect_val("mid_reset_x3", 32'h0);
        expect_val("mid_reset_pc", PC_RST);
        through_posedge();
        check(rs1data);
        check(rs2data);
        check(pc);

        // Normal operation resumes after reset release.
        to_negedge();
        rst = 1'b0;
        expect_val("post_reset_pc", 32'h9000_0000);
        expect_val("post_reset_x7", 32'h7777_7777);
        through_posedge();
        check(pc);
        check(rs1data);

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_leftover: observed %0d expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
